pipe_hazard_ctrl: RTL

Central sequencer for the 5-stage pipelined MIPS32 core (IF/ID/EX/MEM/WB).
- Detects RAW, load-use and control hazards.
- Drives stall, flush and forwarding selects for the pipeline registers.
- Owns the exception/interrupt sequence: EPC/Cause capture and redirect to the exception vector.
- Sits beside the datapath; consumes decoded stage fields and drives every pipeline-register enable and flush.

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/pipe_hazard_ctrl_fwd_unit.sv | 47 ++++
 rtl/pipe_hazard_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the MIPS32 pipeline hazard controller: PC select, forward
// select, controller states, Cause bit positions and the exception vector.
package pipe_pkg;

    localparam logic [31:0] EXC_VECTOR    = 32'h8000_0008;
    localparam logic [31:0] RESET_EPC     = 32'h8000_0000;
    localparam int          RAW_STALL_MAX = 2;

    localparam logic [1:0] PCSEL_PC4 = 2'd0;
    localparam logic [1:0] PCSEL_BR  = 2'd1;
    localparam logic [1:0] PCSEL_JMP = 2'd2;
    localparam logic [1:0] PCSEL_EXC = 2'd3;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    localparam int CAUSE_ERR = 0;
    localparam int CAUSE_OVF = 1;
    localparam int CAUSE_IRQ = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_EXC   = 2'd2
    } state_t;

    // A producer only matches when it really writes a non-zero register.
    function automatic logic reg_match(input logic wr, input logic valid,
                                       input logic [4:0] dst, input logic [4:0] src);
        return wr & valid & (dst != 5'd0) & (dst == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Per-operand match logic: hazard request and forward select for one ID source
// register. FORWARD_EN selects forwarding; otherwise every EX/MEM match is a hazard.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] src,
    input  logic       id_valid,
    input  logic       ex_reg_wr,
    input  logic       ex_mem_rd,
    input  logic       ex_valid,
    input  logic [4:0] ex_reg_dst,
    input  logic       mem_reg_wr,
    input  logic [4:0] mem_reg_dst,
    output logic       hazard,
    output logic       hazard_ex,
    output logic [1:0] fwd
);

    logic ex_match;
    logic mem_match;

    assign ex_match  = id_valid & reg_match(ex_reg_wr, ex_valid, ex_reg_dst, src);
    assign mem_match = id_valid & reg_match(mem_reg_wr, 1'b1, mem_reg_dst, src);

`ifdef FORWARD_EN
    // Only a load in EX cannot be forwarded yet; its data exists one cycle later in MEM.
    assign hazard    = ex_match & ex_mem_rd;
    assign hazard_ex = hazard;

    always_comb begin
        fwd = FWD_RF;
        if (ex_match && !ex_mem_rd) begin
            fwd = FWD_EX;
        end else if (mem_match) begin
            fwd = FWD_MEM;
        end
    end
`else
    logic unused_load;

    assign hazard      = ex_match | mem_match;
    assign hazard_ex   = ex_match;
    assign fwd         = FWD_RF;
    assign unused_load = ex_mem_rd;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/exception sequencer for the 5-stage MIPS32 pipeline. Outputs are
// combinational from state and stage fields. Build option: FORWARD_EN.
module pipe_hazard_ctrl
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_valid,
    input  logic        id_jump,
    input  logic        id_err_inst,
    input  logic [31:0] id_pc,
    input  logic        ex_reg_wr,
    input  logic        ex_mem_rd,
    input  logic [4:0]  ex_reg_dst,
    input  logic        ex_valid,
    input  logic        ex_br_taken,
    input  logic        ex_ovf,
    input  logic [31:0] ex_pc,
    input  logic        mem_reg_wr,
    input  logic [4:0]  mem_reg_dst,
    input  logic        irq_req,
    input  logic        kernel_mode,
    output logic        pc_wr_en,
    output logic        ifid_wr_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic [1:0]  pc_sel,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [31:0] epc,
    output logic [4:0]  cause,
    output logic        in_exc
);

`ifdef FORWARD_EN
    localparam logic [1:0] EX_STALL_LEN = 2'd1;
`else
    localparam logic [1:0] EX_STALL_LEN = 2'(RAW_STALL_MAX);
`endif

    state_t      state_reg, state_next;
    logic [1:0]  stall_cnt_reg, stall_cnt_next;
    logic [31:0] epc_reg, epc_next;
    logic [4:0]  cause_reg, cause_next;

    logic [4:0]  src [2];
    logic [1:0]  hz;
    logic [1:0]  hz_ex;
    logic [1:0]  fwd_sel [2];
    logic        exc_req;
    logic        exc_from_ex;
    logic        br_taken;
    logic        stall_now;

    assign src[0] = id_rs;
    assign src[1] = id_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_unit u_fwd (
                .src        (src[gi]),
                .id_valid   (id_valid),
                .ex_reg_wr  (ex_reg_wr),
                .ex_mem_rd  (ex_mem_rd),
                .ex_valid   (ex_valid),
                .ex_reg_dst (ex_reg_dst),
                .mem_reg_wr (mem_reg_wr),
                .mem_reg_dst(mem_reg_dst),
                .hazard     (hz[gi]),
                .hazard_ex  (hz_ex[gi]),
                .fwd        (fwd_sel[gi])
            );
        end
    endgenerate

    assign fwd_a = fwd_sel[0];
    assign fwd_b = fwd_sel[1];
    assign epc   = epc_reg;
    assign cause = cause_reg;

    assign exc_req     = (ex_ovf & ex_valid) | (id_err_inst & id_valid) | (irq_req & ~kernel_mode);
    assign exc_from_ex = (ex_ovf & ex_valid) | (irq_req & ~kernel_mode & ex_valid);
    assign br_taken    = ex_br_taken & ex_valid;

    always_comb begin
        pc_wr_en       = 1'b1;
        ifid_wr_en     = 1'b1;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        exmem_flush    = 1'b0;
        pc_sel         = PCSEL_PC4;
        in_exc         = 1'b0;
        stall_now      = 1'b0;
        state_next     = state_reg;
        stall_cnt_next = stall_cnt_reg;
        epc_next       = epc_reg;
        cause_next     = cause_reg;

        case (state_reg)
            ST_EXC: begin
                in_exc         = 1'b1;
                ifid_flush     = 1'b1;
                state_next     = ST_RUN;
                stall_cnt_next = 2'd0;
            end
            default: begin
                // In STALL the counter owns the stall; the ID instruction is not re-checked.
                stall_now = (state_reg == ST_RUN) ? (|hz) : (stall_cnt_reg > 2'd1);
                if (state_reg == ST_STALL) begin
                    stall_cnt_next = (stall_cnt_reg != 2'd0) ? stall_cnt_reg - 2'd1 : 2'd0;
                    state_next     = (stall_cnt_reg <= 2'd1) ? ST_RUN : ST_STALL;
                end

                if (exc_req) begin
                    ifid_flush             = 1'b1;
                    idex_flush             = 1'b1;
                    exmem_flush            = 1'b1;
                    pc_sel                 = PCSEL_EXC;
                    state_next             = ST_EXC;
                    stall_cnt_next         = 2'd0;
                    epc_next               = exc_from_ex ? ex_pc : id_pc;
                    cause_next             = 5'd0;
                    cause_next[CAUSE_IRQ]  = irq_req;
                    cause_next[CAUSE_OVF]  = ex_ovf;
                    cause_next[CAUSE_ERR]  = id_err_inst;
                end else if (br_taken) begin
                    ifid_flush     = 1'b1;
                    idex_flush     = 1'b1;
                    pc_sel         = PCSEL_BR;
                    state_next     = ST_RUN;
                    stall_cnt_next = 2'd0;
                end else if (stall_now) begin
                    pc_wr_en   = 1'b0;
                    ifid_wr_en = 1'b0;
                    idex_flush = 1'b1;
                    if (state_reg == ST_RUN) begin
                        stall_cnt_next = (|hz_ex) ? EX_STALL_LEN : 2'd1;
                        state_next     = ST_STALL;
                    end
                end else if (id_jump && id_valid) begin
                    pc_sel     = PCSEL_JMP;
                    ifid_flush = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_RUN;
            stall_cnt_reg <= 2'd0;
            epc_reg       <= RESET_EPC;
            cause_reg     <= 5'd0;
        end else begin
            state_reg     <= state_next;
            stall_cnt_reg <= stall_cnt_next;
            epc_reg       <= epc_next;
            cause_reg     <= cause_next;
        end
    end

endmodule
